// File: rtl/alu_mon_pkg.sv
// alu_mon_pkg: record layout, trigger pattern and FSM states shared by the ALU mismatch monitor
package alu_mon_pkg;
  localparam int REC_W = 24;
  localparam int OFF_FLG_T = 0;
  localparam int OFF_RES_T = 3;
  localparam int OFF_FLG_C = 7;
  localparam int OFF_RES_C = 10;
  localparam int OFF_OP = 14;
  localparam int OFF_B = 16;
  localparam int OFF_A = 20;
  localparam logic [3:0] TRIG_A = 4'hF;
  localparam logic [3:0] TRIG_B = 4'hF;
  localparam logic [1:0] TRIG_OP = 2'b00;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/mon_fifo.sv
// mon_fifo: synchronous record FIFO; a push while full succeeds only alongside a pop, and the output holds the last popped word while empty
module mon_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [WIDTH-1:0] last;
  logic do_pop, do_push;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = empty ? last : mem[rp];
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) last <= '0;
    else if (do_pop) last <= mem[rp];
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/alu_mismatch_monitor.sv
// alu_mismatch_monitor: compares clean vs Trojan ALU results per sample, counts tests/mismatches/trigger hits and queues mismatch records
module alu_mismatch_monitor
  import alu_mon_pkg::*;
#(
  parameter int EXPECT_TESTS = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [3:0]        a,
  input  logic [3:0]        b,
  input  logic [1:0]        op,
  input  logic [3:0]        res_c,
  input  logic [3:0]        res_t,
  input  logic [2:0]        flg_c,
  input  logic [2:0]        flg_t,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [REC_W-1:0]  rd_data,
  output logic [CNT_W-1:0]  test_cnt,
  output logic [CNT_W-1:0]  mis_cnt,
  output logic [CNT_W-1:0]  trig_cnt,
  output logic              drop_sticky,
  output logic              busy,
  output logic              done
);
  localparam int IW = $clog2(EXPECT_TESTS + 1);
  state_t state_q, state_d;
  logic [IW-1:0] issued;
  logic cap_v;
  logic [REC_W-1:0] cap_rec;
  logic flush, capture, mism, trig, push, pop, last, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] level_unused;
  assign flush = clear || (start && state_q == S_DONE);
  assign capture = sample_valid && state_q == S_RUN && issued < IW'(EXPECT_TESTS);
  assign mism = cap_rec[OFF_RES_C +: 4] != cap_rec[OFF_RES_T +: 4] || cap_rec[OFF_FLG_C +: 3] != cap_rec[OFF_FLG_T +: 3];
  assign trig = cap_rec[OFF_A +: 4] == TRIG_A && cap_rec[OFF_B +: 4] == TRIG_B && cap_rec[OFF_OP +: 2] == TRIG_OP;
  assign push = cap_v && mism && !flush;
  assign pop = rd_valid && rd_ready;
  assign last = cap_v && test_cnt == CNT_W'(EXPECT_TESTS - 1);
  assign rd_valid = !fifo_empty;
  assign busy = state_q == S_RUN;
  assign done = state_q == S_DONE;
  always_comb begin
    state_d = clear ? state_q : (start && state_q != S_RUN) ? S_RUN : (last && state_q == S_RUN) ? S_DONE : state_q;
  end
  always_ff @(posedge clk) begin
    state_q <= !rst_n ? S_IDLE : state_d;
  end
  always_ff @(posedge clk) begin
    if (capture) cap_rec <= {a, b, op, res_c, flg_c, res_t, flg_t};
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      test_cnt <= '0;
      mis_cnt <= '0;
      trig_cnt <= '0;
      drop_sticky <= 1'b0;
      issued <= '0;
      cap_v <= 1'b0;
    end else begin
      cap_v <= capture;
      if (capture) issued <= issued + 1'b1;
      if (cap_v) test_cnt <= test_cnt + CNT_W'(!(&test_cnt));
      if (cap_v && mism) mis_cnt <= mis_cnt + CNT_W'(!(&mis_cnt));
      if (cap_v && trig) trig_cnt <= trig_cnt + CNT_W'(!(&trig_cnt));
      if (push && fifo_full && !pop) drop_sticky <= 1'b1;
    end
  end
  mon_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REC_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .wdata (cap_rec),
    .pop   (pop),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_unused)
  );
endmodule

// File: tb/tb_alu_mismatch_monitor.sv
// tb_alu_mismatch_monitor: randomized scoreboard bench with a behavioural reference model
module tb_alu_mismatch_monitor;
  localparam int EXP = 1024;
  localparam int DEP = 8;
  localparam int CW = 16;
  logic clk = 0, rst_n = 0, start = 0, clear = 0, sample_valid = 0, rd_ready = 0;
  logic [3:0] a = 0, b = 0, res_c = 0, res_t = 0;
  logic [1:0] op = 0;
  logic [2:0] flg_c = 0, flg_t = 0;
  logic rd_valid, drop_sticky, busy, done;
  logic [23:0] rd_data;
  logic [CW-1:0] test_cnt, mis_cnt, trig_cnt;
  int n_tests = 0, n_fail = 0;
  bit mon_en = 0;
  logic [23:0] exp_q [$];
  logic [23:0] last_rec = 0;
  int m_st = 0, m_iss = 0, m_lvl = 0, m_test = 0, m_mis = 0, m_trig = 0;
  bit m_drop = 0, m_pend = 0;
  logic [23:0] m_rec = 0;
  always #5 clk = ~clk;
  alu_mismatch_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .sample_valid(sample_valid),
    .a(a), .b(b), .op(op), .res_c(res_c), .res_t(res_t), .flg_c(flg_c), .flg_t(flg_t),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .test_cnt(test_cnt),
    .mis_cnt(mis_cnt), .trig_cnt(trig_cnt), .drop_sticky(drop_sticky), .busy(busy), .done(done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask
  task automatic chk_cnt(input string t);
    chk({t, ".test"}, test_cnt, m_test);
    chk({t, ".mis"}, mis_cnt, m_mis);
    chk({t, ".trig"}, trig_cnt, m_trig);
    chk({t, ".drop"}, drop_sticky, m_drop);
    chk({t, ".busy"}, busy, m_st == 1);
    chk({t, ".done"}, done, m_st == 2);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input bit mm);
    sample_valid = 1;
    a = 4'($urandom);
    b = 4'($urandom);
    op = 2'($urandom);
    res_c = 4'($urandom);
    flg_c = 3'($urandom);
    {res_t, flg_t} = {res_c, flg_c} ^ (mm ? 7'($urandom_range(1, 127)) : 7'd0);
    step();
    sample_valid = 0;
  endtask
  always @(posedge clk) begin
    bit pop, cap;
    if (!rst_n || clear || (start && m_st == 2)) begin
      m_iss = 0; m_pend = 0; m_test = 0; m_mis = 0; m_trig = 0; m_drop = 0; m_lvl = 0;
      exp_q.delete();
      m_st = !rst_n ? 0 : clear ? m_st : 1;
    end else begin
      pop = m_lvl > 0 && rd_ready;
      cap = sample_valid && m_st == 1 && m_iss < EXP;
      if (m_pend) begin
        if (m_test < 65535) m_test++;
        if (m_rec[13:7] != m_rec[6:0]) begin
          if (m_mis < 65535) m_mis++;
          if (m_lvl < DEP || pop) begin
            exp_q.push_back(m_rec);
            m_lvl++;
          end else m_drop = 1;
        end
        if (m_rec[23:14] == 10'h3FC && m_trig < 65535) m_trig++;
        if (m_test == EXP) m_st = 2;
      end
      if (pop) m_lvl--;
      m_pend = cap;
      if (cap) begin
        m_rec = {a, b, op, res_c, flg_c, res_t, flg_t};
        m_iss++;
      end
      if (start && m_st == 0) m_st = 1;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) last_rec = 0;
    else if (mon_en) begin
      chk("rd_valid", rd_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("rd_data", rd_data, exp_q[0]);
        if (rd_ready) last_rec = exp_q.pop_front();
      end else chk("rd_hold", rd_data, last_rec);
    end
  end
  initial begin
    repeat (2) step();
    chk("rst.test", test_cnt, 0);
    chk("rst.mis", mis_cnt, 0);
    chk("rst.trig", trig_cnt, 0);
    chk("rst.drop", drop_sticky, 0);
    chk("rst.rd_valid", rd_valid, 0);
    chk("rst.rd_data", rd_data, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    rst_n = 1;
    mon_en = 1;
    step();
    repeat (5) put(1);
    step();
    chk("idle.test", test_cnt, 0);
    chk_cnt("idle");
    start = 1;
    step();
    start = 0;
    chk("run.busy", busy, 1);
    for (int i = 0; i < 1024; i++) begin
      sample_valid = 1;
      {a, b, op} = 10'(i);
      res_c = 4'($urandom);
      flg_c = 3'($urandom);
      res_t = res_c ^ {3'b0, i == 1020};
      flg_t = flg_c;
      step();
    end
    sample_valid = 0;
    repeat (2) step();
    chk("exh.test", test_cnt, 1024);
    chk("exh.trig", trig_cnt, 1);
    chk("exh.mis", mis_cnt, 1);
    chk("exh.done", done, 1);
    chk("exh.busy", busy, 0);
    chk("exh.rd_valid", rd_valid, 1);
    chk_cnt("exh");
    rd_ready = 1;
    repeat (2) step();
    rd_ready = 0;
    chk("exh.drained", rd_valid, 0);
    repeat (5) put(1);
    step();
    chk("done.test", test_cnt, 1024);
    chk("done.done", done, 1);
    start = 1;
    step();
    start = 0;
    chk("restart.test", test_cnt, 0);
    chk("restart.busy", busy, 1);
    repeat (10) put(1);
    repeat (2) step();
    chk("ovf.mis", mis_cnt, 10);
    chk("ovf.drop", drop_sticky, 1);
    chk_cnt("ovf");
    rd_ready = 1;
    repeat (10) step();
    rd_ready = 0;
    chk("ovf.drained", rd_valid, 0);
    clear = 1;
    step();
    clear = 0;
    chk("clr.drop", drop_sticky, 0);
    chk("clr.busy", busy, 1);
    repeat (8) put(1);
    step();
    chk("full.rd_valid", rd_valid, 1);
    put(1);
    rd_ready = 1;
    step();
    rd_ready = 0;
    chk("full_pp.drop", drop_sticky, 0);
    chk("full_pp.mis", mis_cnt, 9);
    rd_ready = 1;
    repeat (7) step();
    chk("full_pp.lvl_last", rd_valid, 1);
    step();
    rd_ready = 0;
    chk("full_pp.empty", rd_valid, 0);
    for (int i = 0; i < 100; i++) begin
      rd_ready = 1'($urandom);
      put($urandom_range(0, 3) == 0);
    end
    clear = 1;
    rd_ready = 0;
    step();
    clear = 0;
    chk("mclr.test", test_cnt, 0);
    chk("mclr.rd_valid", rd_valid, 0);
    chk("mclr.busy", busy, 1);
    put(0);
    step();
    chk("mclr.next", test_cnt, 1);
    for (int i = 0; i < 400; i++) begin
      rd_ready = 1'($urandom);
      if ($urandom_range(0, 2) != 0) put($urandom_range(0, 2) == 0);
      else step();
      if (i % 50 == 49) chk_cnt("rnd");
    end
    rd_ready = 1;
    repeat (10) step();
    rd_ready = 0;
    chk_cnt("rnd_end");
    repeat (3) put(1);
    step();
    chk("rst_mid.queued", rd_valid, 1);
    put(1);
    rst_n = 0;
    step();
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.done", done, 0);
    chk("rst_mid.rd_valid", rd_valid, 0);
    chk("rst_mid.rd_data", rd_data, 0);
    chk("rst_mid.test", test_cnt, 0);
    chk("rst_mid.mis", mis_cnt, 0);
    chk("rst_mid.trig", trig_cnt, 0);
    chk("rst_mid.drop", drop_sticky, 0);
    rst_n = 1;
    repeat (3) step();
    chk("rst_mid.test_after", test_cnt, 0);
    chk_cnt("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mismatch_monitor.md
ALU_MISMATCH_MONITOR -- requirements
Module: alu_mismatch_monitor

Interface
REQ-001 Parameter EXPECT_TESTS, default 1024, number of samples per run.
REQ-002 Parameter FIFO_DEPTH, default 8, mismatch-record FIFO entries (power of 2).
REQ-003 Parameter CNT_W, default 16, width of all statistics counters.
REQ-004 Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  pulse; begin run.
- clear  in  1  pulse; flush counters and FIFO.
- sample_valid  in  1  operand/result set valid this cycle.
- a, b  in  4 each  ALU operands.
- op  in  2  ALU opcode.
- res_c, res_t  in  4 each  clean/Trojan result.
- flg_c, flg_t  in  3 each  clean/Trojan {carry,zero,overflow}.
- rd_ready  in  1  record consumer ready.
- rd_valid  out  1  record available.
- rd_data  out  24  {a,b,op,res_c,flg_c,res_t,flg_t}, MSB first.
- test_cnt, mis_cnt, trig_cnt  out  CNT_W each  samples / mismatches / trigger hits.
- drop_sticky  out  1  record lost to full FIFO.
- busy, done  out  1 each  FSM in RUN / DONE.

Function
REQ-005 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on commit edge where test_cnt becomes EXPECT_TESTS; DONE->RUN on start (counters, sticky, FIFO cleared same edge); start in RUN ignored.
REQ-006 Capture stage: sample registered when sample_valid, state RUN, and issued count < EXPECT_TESTS; otherwise ignored.
REQ-007 Commit stage: one edge after capture, test_cnt +1; mismatch (res or any flag differs) -> mis_cnt +1 and record pushed; trigger (a=4'hF, b=4'hF, op=2'b00) -> trig_cnt +1 independent of mismatch.
REQ-008 Latency: sample at edge N visible in counters after edge N+1; record rd_valid after edge N+1.
REQ-009 Counters saturate at all-ones; no wrap.
REQ-010 FIFO read: pop on rd_valid & rd_ready; rd_data stable while rd_valid & !rd_ready.
REQ-011 FIFO full push: accepted if same-cycle pop, else dropped, drop_sticky set, mis_cnt still increments.
REQ-012 FIFO empty: rd_valid=0, rd_data holds last value.
REQ-013 clear: counters, drop_sticky, FIFO, issued count and in-flight capture zeroed; state unchanged; priority rst_n > clear > start > normal.
REQ-014 done=1 only in DONE; busy=1 only in RUN.

Reset
REQ-015 On rst_n=0 at edge: state IDLE; all counters 0; drop_sticky 0; FIFO empty; rd_valid 0; rd_data 0; capture stage invalid.
REQ-016 Reset mid-run discards in-flight sample and all records; no output change beyond REQ-015.

Structure
REQ-017 Package alu_mon_pkg holds record width 24, field offsets, trigger constants (A, B, op), FSM state enum.
REQ-018 Record storage in sub-module mon_fifo (synchronous FIFO, parameterised depth/width, full/empty/level).

Verification
REQ-019 Exhaustive 1024 samples, identical results except a=F,b=F,op=0 -> test_cnt=1024, trig_cnt=1, mis_cnt=1, one record, done=1.
REQ-020 10 consecutive mismatches, rd_ready=0 -> 8 records held, drop_sticky=1, mis_cnt=10; then drain -> first 8 records in order.
REQ-021 FIFO full, push and pop same cycle -> level stays 8, drop_sticky=0.
REQ-022 sample_valid in IDLE and DONE, 5 each -> test_cnt unchanged.
REQ-023 clear during RUN after 100 samples -> test_cnt=0, FIFO empty, busy=1, next sample gives test_cnt=1.
REQ-024 rst_n low mid-run with 3 records queued -> state IDLE, rd_valid=0, all counters 0 after that edge.
